hw_barrier_arrival_ctrl: RTL and testbench
==========================================

// Module: hw_barrier_arrival_ctrl
// PURPOSE
//  Upstream front end of the per-cluster HW barrier bank. Takes barrier-arrival requests from
//  every core and configuration accesses from the peripheral bus. Drives the bank's per-barrier
//  get / store / clear pulses and its team configuration. Serialises simultaneous arrivals on
//  one barrier so the bank never sees more than one get per barrier per cycle.
// PARAMETERS
//  NUM_CORES     4  number of cores issuing arrivals
//  NUM_BARRIERS  8  number of HW barriers in the bank
//  (derived) CW = $clog2(NUM_CORES)+1 counter/thread width; BW = $clog2(NUM_BARRIERS) index width
// PORTS
//  clk_i                 in   1                 cluster clock
//  rst_ni                in   1                 synchronous active-low reset
//  arrive_req_i          in   NUM_CORES         core c requests arrival; held until ack
//  arrive_id_i           in   NUM_CORES x 8     barrier index per core, stable while req high
//  arrive_ack_o          out  NUM_CORES         1-cycle ack, arrival forwarded to the bank
//  cfg_req_i             in   1                 peripheral bus request
//  cfg_we_i              in   1                 1 = write, 0 = read
//  cfg_addr_i            in   BW+4              byte address: [BW+3:4] barrier, [3:2] register
//  cfg_wdata_i           in   32                write data
//  cfg_gnt_o             out  1                 grant (= cfg_req_i, never stalls)
//  cfg_rvalid_o          out  1                 response valid, 1 cycle after grant (reads and writes)
//  cfg_rdata_o           out  32                read data, valid with cfg_rvalid_o
//  barrier_get_o         out  NUM_BARRIERS      1-cycle arrival pulse per barrier
//  team_num_threads_o    out  NUM_BARRIERS x CW shadow thread count per barrier
//  mask_to_trigger_o     out  NUM_BARRIERS x NUM_CORES  shadow wake mask per barrier
//  store_team_data_o     out  NUM_BARRIERS      1-cycle commit pulse of shadow config
//  clear_barrier_req_o   out  NUM_BARRIERS      1-cycle counter clear pulse
//  barrier_counter_i     in   NUM_BARRIERS x CW arrival count returned by the bank
// BEHAVIOUR
//  - Reset (sync, rst_ni low at posedge): all outputs 0, shadows 0, RR pointers 0,
//    pending pulses discarded. The reset has effect even mid-arbitration or mid-access.
//  - Register map per barrier b (stride 0x10):
//      0x0 NUM_THREADS (RW, low CW bits)
//      0x4 MASK (RW, low NUM_CORES bits)
//      0x8 CLEAR (WO, any data)
//      0xC COUNTER (RO, barrier_counter_i[b])
//  - Write NUM_THREADS/MASK at cycle t: shadow updates at t+1. store_team_data_o[b]=1 during t+1 only.
//  - Write CLEAR at t: clear_barrier_req_o[b]=1 during t+1 only.
//  - Reads return zero-extended value; unused bits and write-only registers read 0.
//  - Barrier index >= NUM_BARRIERS: writes ignored, reads 0. Response still given.
//  - Arrival arbitration, each cycle, independently per barrier b:
//    - Candidates: cores with req=1, id=b, and ack_o currently 0 (prevents a double grant
//      on the ack cycle).
//    - Round-robin from rr_ptr[b]. Winner c gets arrive_ack_o[c]=1 and barrier_get_o[b]=1
//      in the next cycle (registered, latency 1).
//    - After a grant to c, rr_ptr[b] = (c+1) mod NUM_CORES.
//    - Different barriers grant in the same cycle independently.
//  - Blocking: if cfg targets barrier b with a store-causing or CLEAR write in cycle t, no
//    arrival on b is granted in t. Config has priority; arrivals retry next cycle.
//  - Arrival id >= NUM_BARRIERS: acked next cycle (unless acked this cycle). No get issued.
//  - Cores losing arbitration keep req high; fairness bound is NUM_CORES-1 waiting cycles.
//  - No counting here: thread-count compare and event generation stay in the bank.
// TESTING
//  1. Reset:
//     - rst_ni=0 for 2 cycles with reqs high -> all acks/gets/store/clear 0, rdata 0.
//  2. Config write:
//     - Write 0x13 (b=1, NUM_THREADS), data 4 -> next cycle team_num_threads_o[1]=4,
//       store_team_data_o[1]=1 for exactly 1 cycle.
//     - Read 0x14 -> 0 (MASK still at reset value).
//  3. Contention:
//     - Cores 0-3 req id 2 at t0 -> acks to cores 0,1,2,3 at t1..t4, one per cycle.
//     - barrier_get_o[2] high t1..t4.
//     - Cores 0 and 1 req id 3 -> grants parallel to barrier 2.
//  4. Round-robin wrap:
//     - After core 3 granted on b0, cores 0 and 3 request b0 -> core 0 first, then core 3.
//  5. Collision:
//     - CLEAR write b5 and core 1 arrival b5 in the same cycle -> clear pulse first.
//     - Core 1 acked one cycle later than unblocked.
//     - Arrival id 9 with NUM_BARRIERS=8 -> ack, no get.
//  6. Readback:
//     - barrier_counter_i[6]=3, read 0x6C -> cfg_rvalid_o next cycle, rdata 3.

Source files
------------

// File: rtl/hw_barrier_arrival_ctrl.sv
// Front end of the cluster HW barrier bank: arbitrates core arrivals per barrier and
// decodes peripheral-bus configuration into shadow team config plus store/clear pulses.
module hw_barrier_arrival_ctrl #(
  parameter int NUM_CORES    = 4,
  parameter int NUM_BARRIERS = 8,
  localparam int CW = $clog2(NUM_CORES) + 1,
  localparam int BW = $clog2(NUM_BARRIERS)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NUM_CORES-1:0]                    arrive_req_i,
  input  logic [NUM_CORES-1:0][7:0]               arrive_id_i,
  output logic [NUM_CORES-1:0]                    arrive_ack_o,
  input  logic                                    cfg_req_i,
  input  logic                                    cfg_we_i,
  input  logic [BW+3:0]                           cfg_addr_i,
  input  logic [31:0]                             cfg_wdata_i,
  output logic                                    cfg_gnt_o,
  output logic                                    cfg_rvalid_o,
  output logic [31:0]                             cfg_rdata_o,
  output logic [NUM_BARRIERS-1:0]                 barrier_get_o,
  output logic [NUM_BARRIERS-1:0][CW-1:0]         team_num_threads_o,
  output logic [NUM_BARRIERS-1:0][NUM_CORES-1:0]  mask_to_trigger_o,
  output logic [NUM_BARRIERS-1:0]                 store_team_data_o,
  output logic [NUM_BARRIERS-1:0]                 clear_barrier_req_o,
  input  logic [NUM_BARRIERS-1:0][CW-1:0]         barrier_counter_i
);

  // Handshakes: a core holds arrive_req_i (and a stable id) until it sees the one-cycle
  // arrive_ack_o. The bus is granted in the request cycle and answered by a one-cycle
  // cfg_rvalid_o on the following cycle for both reads and writes.

  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [1:0] REG_THREADS = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_CLEAR   = 2'd2;
  localparam logic [1:0] REG_COUNTER = 2'd3;

  logic [BW-1:0]                          cfg_bar;
  logic [1:0]                             cfg_reg;
  logic                                   cfg_bar_ok;
  logic                                   wr_store;
  logic                                   wr_clear;
  logic [NUM_BARRIERS-1:0]                bar_onehot;
  logic [NUM_BARRIERS-1:0]                blocked;
  logic [31:0]                            rdata_d;

  logic [NUM_BARRIERS-1:0][NUM_CORES-1:0] cand;
  logic [NUM_BARRIERS-1:0][PW:0]          pick;
  logic [NUM_BARRIERS-1:0][NUM_CORES-1:0] grant_d;
  logic [NUM_BARRIERS-1:0]                get_d;
  logic [NUM_BARRIERS-1:0][PW-1:0]        next_ptr;
  logic [NUM_CORES-1:0]                   inv_d;
  logic [NUM_CORES-1:0]                   ack_d;

  logic [NUM_BARRIERS-1:0][PW-1:0]        rr_q;
  logic [NUM_CORES-1:0]                   ack_q;
  logic [NUM_BARRIERS-1:0]                get_q;
  logic [NUM_BARRIERS-1:0][CW-1:0]        thr_q;
  logic [NUM_BARRIERS-1:0][NUM_CORES-1:0] mask_q;
  logic [NUM_BARRIERS-1:0]                store_q;
  logic [NUM_BARRIERS-1:0]                clear_q;
  logic                                   rvalid_q;
  logic [31:0]                            rdata_q;

  logic unused_bits;
  assign unused_bits = ^{cfg_addr_i[1:0], cfg_wdata_i};

  // First candidate at or after ptr; returns {found, winner}.
  function automatic logic [PW:0] rr_pick(input logic [NUM_CORES-1:0] c,
                                          input logic [PW-1:0] ptr);
    logic          found;
    logic [PW-1:0] win;
    int            idx;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = (int'(ptr) + i) % NUM_CORES;
      if (!found && c[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
    return {found, win};
  endfunction

  // Config decode
  assign cfg_bar    = cfg_addr_i[BW+3:4];
  assign cfg_reg    = cfg_addr_i[3:2];
  assign cfg_bar_ok = int'(cfg_bar) < NUM_BARRIERS;
  assign wr_store   = cfg_req_i && cfg_we_i && cfg_bar_ok &&
                      (cfg_reg == REG_THREADS || cfg_reg == REG_MASK);
  assign wr_clear   = cfg_req_i && cfg_we_i && cfg_bar_ok && (cfg_reg == REG_CLEAR);
  assign bar_onehot = NUM_BARRIERS'(1) << cfg_bar;
  assign blocked    = (wr_store || wr_clear) ? bar_onehot : '0;

  always_comb begin
    rdata_d = '0;
    if (cfg_req_i && !cfg_we_i && cfg_bar_ok) begin
      case (cfg_reg)
        REG_THREADS: rdata_d[CW-1:0]        = thr_q[cfg_bar];
        REG_MASK:    rdata_d[NUM_CORES-1:0] = mask_q[cfg_bar];
        REG_COUNTER: rdata_d[CW-1:0]        = barrier_counter_i[cfg_bar];
        default:     rdata_d                = '0;
      endcase
    end
  end

  // Arrival arbitration: a core already being acked is excluded so it cannot win twice.
  always_comb begin
    cand = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        cand[b][c] = arrive_req_i[c] && (arrive_id_i[c] == 8'(b)) && !ack_q[c] && !blocked[b];
      end
    end
  end

  always_comb begin
    pick     = '0;
    grant_d  = '0;
    get_d    = '0;
    next_ptr = rr_q;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      pick[b] = rr_pick(cand[b], rr_q[b]);
      if (pick[b][PW]) begin
        grant_d[b]  = NUM_CORES'(1) << pick[b][PW-1:0];
        get_d[b]    = 1'b1;
        next_ptr[b] = PW'((int'(pick[b][PW-1:0]) + 1) % NUM_CORES);
      end
    end
  end

  // Arrivals on non-existent barriers are simply acknowledged.
  always_comb begin
    inv_d = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      inv_d[c] = arrive_req_i[c] && (int'(arrive_id_i[c]) >= NUM_BARRIERS) && !ack_q[c];
    end
  end

  always_comb begin
    ack_d = inv_d;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      ack_d = ack_d | grant_d[b];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      ack_q    <= '0;
      get_q    <= '0;
      thr_q    <= '0;
      mask_q   <= '0;
      store_q  <= '0;
      clear_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rr_q     <= next_ptr;
      ack_q    <= ack_d;
      get_q    <= get_d;
      store_q  <= wr_store ? bar_onehot : '0;
      clear_q  <= wr_clear ? bar_onehot : '0;
      rvalid_q <= cfg_req_i;
      rdata_q  <= rdata_d;
      if (wr_store && cfg_reg == REG_THREADS) thr_q[cfg_bar]  <= cfg_wdata_i[CW-1:0];
      if (wr_store && cfg_reg == REG_MASK)    mask_q[cfg_bar] <= cfg_wdata_i[NUM_CORES-1:0];
    end
  end

  assign arrive_ack_o        = ack_q;
  assign barrier_get_o       = get_q;
  assign team_num_threads_o  = thr_q;
  assign mask_to_trigger_o   = mask_q;
  assign store_team_data_o   = store_q;
  assign clear_barrier_req_o = clear_q;
  assign cfg_gnt_o           = cfg_req_i;
  assign cfg_rvalid_o        = rvalid_q;
  assign cfg_rdata_o         = rdata_q;

endmodule

// File: tb/tb_hw_barrier_arrival_ctrl.sv
// Bench for hw_barrier_arrival_ctrl: hand-written arrival sequences checked against an
// expected-packet queue, then a table of config accesses checked against a shadow model.
module tb_hw_barrier_arrival_ctrl;

  localparam int NC = 4;
  localparam int NB = 8;
  localparam int CW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NC-1:0]          arrive_req;
  logic [NC-1:0][7:0]     arrive_id;
  logic [NC-1:0]          arrive_ack;
  logic                   cfg_req;
  logic                   cfg_we;
  logic [6:0]             cfg_addr;
  logic [31:0]            cfg_wdata;
  logic                   cfg_gnt;
  logic                   cfg_rvalid;
  logic [31:0]            cfg_rdata;
  logic [NB-1:0]          barrier_get;
  logic [NB-1:0][CW-1:0]  team_num_threads;
  logic [NB-1:0][NC-1:0]  mask_to_trigger;
  logic [NB-1:0]          store_team_data;
  logic [NB-1:0]          clear_barrier_req;
  logic [NB-1:0][CW-1:0]  barrier_counter;

  hw_barrier_arrival_ctrl #(.NUM_CORES(NC), .NUM_BARRIERS(NB)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .arrive_req_i        (arrive_req),
    .arrive_id_i         (arrive_id),
    .arrive_ack_o        (arrive_ack),
    .cfg_req_i           (cfg_req),
    .cfg_we_i            (cfg_we),
    .cfg_addr_i          (cfg_addr),
    .cfg_wdata_i         (cfg_wdata),
    .cfg_gnt_o           (cfg_gnt),
    .cfg_rvalid_o        (cfg_rvalid),
    .cfg_rdata_o         (cfg_rdata),
    .barrier_get_o       (barrier_get),
    .team_num_threads_o  (team_num_threads),
    .mask_to_trigger_o   (mask_to_trigger),
    .store_team_data_o   (store_team_data),
    .clear_barrier_req_o (clear_barrier_req),
    .barrier_counter_i   (barrier_counter)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_store;
    logic [7:0]  exp_clear;
  } cfg_vec_t;

  cfg_vec_t              vecs[15];
  logic [27:0]           exp_q[$];   // {ack, get, store, clear}
  logic [31:0]           rd_q[$];
  logic [NB-1:0][CW-1:0] m_thr;
  logic [NB-1:0][NC-1:0] m_mask;
  int                    n_checks = 0;
  int                    n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int c, input logic r, input logic [7:0] id);
    arrive_req[c] = r;
    arrive_id[c]  = id;
  endtask

  task automatic push_exp(input logic [3:0] ack, input logic [7:0] get,
                          input logic [7:0] st, input logic [7:0] cl);
    exp_q.push_back({ack, get, st, cl});
  endtask

  task automatic cfg_drive(input logic we, input logic [6:0] addr, input logic [31:0] wd);
    cfg_req   = 1'b1;
    cfg_we    = we;
    cfg_addr  = addr;
    cfg_wdata = wd;
  endtask

  // Each cycle: compare the arrival outputs to the next expected packet, drop acked reqs.
  task automatic run_arrival(input int n);
    logic [27:0] pkt;
    for (int i = 0; i < n; i++) begin
      tick();
      cfg_req = 1'b0;
      if (exp_q.size() == 0) begin
        check("arrival_queue_empty", 32'd1, 32'd0);
      end else begin
        pkt = exp_q.pop_front();
        check("arrival", 32'({arrive_ack, barrier_get, store_team_data, clear_barrier_req}),
              32'(pkt));
      end
      for (int c = 0; c < NC; c++) if (arrive_ack[c]) arrive_req[c] = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] rnd_mask;
    logic [6:0]  a;

    // ---------------- stimulus table ----------------
    for (int b = 0; b < NB; b++) barrier_counter[b] = CW'($urandom_range(0, 7));
    barrier_counter[6] = 3'd3;
    rnd_mask = $urandom_range(0, 32'hFFFF);
    vecs[0]  = '{1'b1, 7'h13, 32'd4,          32'd0, 8'h02, 8'h00};
    vecs[1]  = '{1'b0, 7'h14, 32'd0,          32'd0, 8'h00, 8'h00};
    vecs[2]  = '{1'b1, 7'h14, rnd_mask,       32'd0, 8'h02, 8'h00};
    vecs[3]  = '{1'b0, 7'h14, 32'd0,          rnd_mask & 32'hF, 8'h00, 8'h00};
    vecs[4]  = '{1'b0, 7'h10, 32'd0,          32'd4, 8'h00, 8'h00};
    vecs[5]  = '{1'b1, 7'h10, 32'hFFFF_FFFF,  32'd0, 8'h02, 8'h00};
    vecs[6]  = '{1'b0, 7'h10, 32'd0,          32'd7, 8'h00, 8'h00};
    vecs[7]  = '{1'b0, 7'h18, 32'd0,          32'd0, 8'h00, 8'h00};
    vecs[8]  = '{1'b1, 7'h38, 32'h1234_5678,  32'd0, 8'h00, 8'h08};
    vecs[9]  = '{1'b0, 7'h6C, 32'd0,          32'd3, 8'h00, 8'h00};
    vecs[10] = '{1'b0, 7'h2C, 32'd0,          32'(barrier_counter[2]), 8'h00, 8'h00};
    vecs[11] = '{1'b0, 7'h44, 32'd0,          32'd5, 8'h00, 8'h00};
    vecs[12] = '{1'b0, 7'h1C, 32'd0,          32'(barrier_counter[1]), 8'h00, 8'h00};
    vecs[13] = '{1'b1, 7'h7C, 32'hFFFF_FFFF,  32'd0, 8'h00, 8'h00};
    vecs[14] = '{1'b0, 7'h74, 32'd0,          32'd0, 8'h00, 8'h00};

    m_thr      = '0;
    m_mask     = '0;
    arrive_req = '0;
    arrive_id  = '0;
    cfg_req    = 1'b0;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_wdata  = '0;

    // ---------------- reset with traffic pending ----------------
    rst_n = 1'b0;
    for (int c = 0; c < NC; c++) set_core(c, 1'b1, 8'd2);
    cfg_drive(1'b1, 7'h58, 32'd1);
    tick();
    cfg_drive(1'b0, 7'h6C, 32'd0);
    for (int i = 0; i < 2; i++) begin
      if (i == 1) tick();
      check("reset_outputs", 32'({arrive_ack, barrier_get, store_team_data, clear_barrier_req}), 32'd0);
      check("reset_rvalid", 32'(cfg_rvalid), 32'd0);
      check("reset_rdata", cfg_rdata, 32'd0);
      check("reset_shadow", 32'({team_num_threads, mask_to_trigger}), 32'd0);
    end
    rst_n   = 1'b1;
    cfg_req = 1'b0;

    // ---------------- contention on barrier 2 (reqs still held from reset) ----------------
    push_exp(4'b0001, 8'h04, 8'h00, 8'h00);
    push_exp(4'b0010, 8'h04, 8'h00, 8'h00);
    push_exp(4'b0100, 8'h04, 8'h00, 8'h00);
    push_exp(4'b1000, 8'h04, 8'h00, 8'h00);
    push_exp(4'b0000, 8'h00, 8'h00, 8'h00);
    run_arrival(5);

    // ---------------- barriers 2 and 3 in parallel ----------------
    set_core(0, 1'b1, 8'd3); set_core(1, 1'b1, 8'd3);
    set_core(2, 1'b1, 8'd2); set_core(3, 1'b1, 8'd2);
    push_exp(4'b0101, 8'h0C, 8'h00, 8'h00);
    push_exp(4'b1010, 8'h0C, 8'h00, 8'h00);
    push_exp(4'b0000, 8'h00, 8'h00, 8'h00);
    run_arrival(3);

    // ---------------- round-robin wrap on barrier 0 ----------------
    set_core(3, 1'b1, 8'd0);
    push_exp(4'b1000, 8'h01, 8'h00, 8'h00);
    push_exp(4'b0000, 8'h00, 8'h00, 8'h00);
    run_arrival(2);
    set_core(0, 1'b1, 8'd0); set_core(3, 1'b1, 8'd0);
    push_exp(4'b0001, 8'h01, 8'h00, 8'h00);
    push_exp(4'b1000, 8'h01, 8'h00, 8'h00);
    push_exp(4'b0000, 8'h00, 8'h00, 8'h00);
    run_arrival(3);

    // ---------------- CLEAR collides with arrival on barrier 5 ----------------
    cfg_drive(1'b1, 7'h58, 32'hDEAD_BEEF);
    set_core(1, 1'b1, 8'd5);
    push_exp(4'b0000, 8'h00, 8'h00, 8'h20);
    push_exp(4'b0010, 8'h20, 8'h00, 8'h00);
    push_exp(4'b0000, 8'h00, 8'h00, 8'h00);
    run_arrival(3);

    // ---------------- MASK write collides with arrival on barrier 4 ----------------
    cfg_drive(1'b1, 7'h44, 32'h0000_0005);
    set_core(2, 1'b1, 8'd4);
    push_exp(4'b0000, 8'h00, 8'h10, 8'h00);
    push_exp(4'b0100, 8'h10, 8'h00, 8'h00);
    push_exp(4'b0000, 8'h00, 8'h00, 8'h00);
    run_arrival(3);
    m_mask[4] = 4'h5;
    check("mask_b4", 32'(mask_to_trigger), 32'(m_mask));

    // ---------------- out-of-range arrival ids ----------------
    set_core(0, 1'b1, 8'd200); set_core(2, 1'b1, 8'd9);
    push_exp(4'b0101, 8'h00, 8'h00, 8'h00);
    push_exp(4'b0000, 8'h00, 8'h00, 8'h00);
    run_arrival(2);

    // ---------------- config table ----------------
    for (int i = 0; i < 15; i++) begin
      cfg_drive(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      rd_q.push_back(vecs[i].exp_rdata);
      a = vecs[i].addr;
      if (vecs[i].we && a[3:2] == 2'd0) m_thr[a[6:4]]  = vecs[i].wdata[CW-1:0];
      if (vecs[i].we && a[3:2] == 2'd1) m_mask[a[6:4]] = vecs[i].wdata[NC-1:0];
      check($sformatf("cfg_gnt[%0d]", i), 32'(cfg_gnt), 32'd1);
      tick();
      check($sformatf("cfg_rvalid[%0d]", i), 32'(cfg_rvalid), 32'd1);
      check($sformatf("cfg_rdata[%0d]", i), cfg_rdata, rd_q.pop_front());
      check($sformatf("cfg_store[%0d]", i), 32'(store_team_data), 32'(vecs[i].exp_store));
      check($sformatf("cfg_clear[%0d]", i), 32'(clear_barrier_req), 32'(vecs[i].exp_clear));
      check($sformatf("cfg_threads[%0d]", i), 32'(team_num_threads), 32'(m_thr));
      check($sformatf("cfg_mask[%0d]", i), 32'(mask_to_trigger), 32'(m_mask));
    end
    cfg_req = 1'b0;
    tick();
    check("cfg_idle_rvalid", 32'(cfg_rvalid), 32'd0);
    check("cfg_idle_pulses", 32'({store_team_data, clear_barrier_req}), 32'd0);
    check("cfg_idle_gnt", 32'(cfg_gnt), 32'd0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
